// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, FSM state type and LFSR default seed for the JAM cost table.
// Optional feature macro: JAM_COST_LFSR_EN (adds the S_GEN state for LFSR table fill).
package jam_pkg;

  localparam int unsigned COST_W = 7;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned N_ENT  = 64;
  localparam int unsigned SUM_W  = 13;
  localparam int unsigned ADDR_W = 2 * IDX_W;

  localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;

`ifdef JAM_COST_LFSR_EN
  typedef enum logic [1:0] {S_LOAD, S_SERVE, S_GEN} state_e;
`else
  typedef enum logic [1:0] {S_LOAD, S_SERVE} state_e;
`endif

endpackage

// File: rtl/jam_lfsr16.sv
// jam_lfsr16: 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1 (right-shifting form).
// Ports:
//   CLK, RST   clock, asynchronous active-high reset (state returns to LFSR_DEF_SEED)
//   load       load seed this cycle (a zero seed is replaced by LFSR_DEF_SEED); wins over step
//   seed[15:0] seed value
//   step       advance one position
//   state[15:0] current LFSR state
module jam_lfsr16
  import jam_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic        fb;

  assign fb    = state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5];
  assign state = state_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LFSR_DEF_SEED;
    end else if (load) begin
      // An all-zero state would lock up the LFSR.
      state_q <= (seed == 16'd0) ? LFSR_DEF_SEED : seed;
    end else if (step) begin
      state_q <= {fb, state_q[15:1]};
    end
  end

endmodule

// File: rtl/jam_cost_rom.sv
// jam_cost_rom: 8x8 worker/job cost table for the JAM engine.
// Loaded row-major ({W,J}) through a valid/ready stream, then answers W/J lookups with a
// registered Cost one cycle later.
// Ports:
//   CLK, RST         clock, asynchronous active-high reset
//   W, J             lookup indices from the engine
//   Cost             registered tbl[{W,J}], 0 outside S_SERVE
//   ld_valid/ld_data load beat stream; ld_ready high while in S_LOAD
//   ld_start         restart loading at entry 0 (highest priority)
//   tbl_ready        all 64 entries loaded, lookups valid
//   ld_sum           running sum of entries loaded since the last start
//   gen_start, seed  (JAM_COST_LFSR_EN only) fill the table from a 16-bit LFSR
module jam_cost_rom
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              ld_valid,
  input  logic [COST_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_start,
  output logic              tbl_ready,
`ifdef JAM_COST_LFSR_EN
  input  logic              gen_start,
  input  logic [15:0]       seed,
`endif
  output logic [SUM_W-1:0]  ld_sum
);

  localparam logic [ADDR_W-1:0] LastEnt = ADDR_W'(N_ENT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic [COST_W-1:0]   tbl_q [N_ENT];
  logic                wr_en;
  logic [COST_W-1:0]   wr_data;

`ifdef JAM_COST_LFSR_EN
  logic        lfsr_load;
  logic        lfsr_step;
  logic [15:0] lfsr_state;
  logic        unused_lfsr_hi;

  assign unused_lfsr_hi = ^lfsr_state[15:COST_W];

  jam_lfsr16 u_lfsr (
    .CLK   (CLK),
    .RST   (RST),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .state (lfsr_state)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cost_d  = '0;
    wr_en   = 1'b0;
    wr_data = ld_data;
`ifdef JAM_COST_LFSR_EN
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
`endif

    unique case (state_q)
      S_LOAD: begin
        if (ld_valid) begin
          wr_en = 1'b1;
          sum_d = sum_q + SUM_W'(ld_data);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastEnt) state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        cost_d = tbl_q[{W, J}];
      end
`ifdef JAM_COST_LFSR_EN
      S_GEN: begin
        wr_en     = 1'b1;
        wr_data   = lfsr_state[COST_W-1:0];
        lfsr_step = 1'b1;
        sum_d     = sum_q + SUM_W'(lfsr_state[COST_W-1:0]);
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LastEnt) state_d = S_SERVE;
      end
`endif
      default: state_d = S_LOAD;
    endcase

`ifdef JAM_COST_LFSR_EN
    if (gen_start) begin
      state_d   = S_GEN;
      cnt_d     = '0;
      sum_d     = '0;
      cost_d    = '0;
      wr_en     = 1'b0;
      lfsr_load = 1'b1;
      lfsr_step = 1'b0;
    end
`endif

    // ld_start overrides everything, including a beat or gen_start in the same cycle.
    if (ld_start) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      sum_d   = '0;
      cost_d  = '0;
      wr_en   = 1'b0;
`ifdef JAM_COST_LFSR_EN
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      sum_q   <= '0;
      cost_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cost_q  <= cost_d;
    end
  end

  // Table contents are deliberately not reset; Cost is forced to 0 until a full load completes.
  always_ff @(posedge CLK) begin
    if (wr_en) tbl_q[cnt_q] <= wr_data;
  end

  assign Cost      = cost_q;
  assign ld_ready  = (state_q == S_LOAD);
  assign tbl_ready = (state_q == S_SERVE);
  assign ld_sum    = sum_q;

endmodule

// File: tb/tb_jam_cost_rom.sv
// Self-checking bench for jam_cost_rom: table-driven lookups plus randomized traffic
// checked against a behavioural model of the cost table.
module tb_jam_cost_rom;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] W, J;
  logic [6:0] Cost;
  logic       ld_valid;
  logic [6:0] ld_data;
  logic       ld_ready;
  logic       ld_start;
  logic       tbl_ready;
  logic [12:0] ld_sum;
  logic       gen_start;
  logic [15:0] seed;

  jam_cost_rom dut (
    .CLK       (CLK),
    .RST       (RST),
    .W         (W),
    .J         (J),
    .Cost      (Cost),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_start  (ld_start),
    .tbl_ready (tbl_ready),
`ifdef JAM_COST_LFSR_EN
    .gen_start (gen_start),
    .seed      (seed),
`endif
    .ld_sum    (ld_sum)
  );

  always #5 CLK = ~CLK;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model: mode 0 = loading, 1 = serving, 2 = generating.
  int m_mode, m_cnt, m_sum, m_cost;
  int m_lfsr;
  int m_tbl [64];

  typedef struct {
    int w;
    int j;
    int cost;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_sum = 0; m_cost = 0;
  endtask

  task automatic model_step();
    if (ld_start) begin
      model_reset();
`ifdef JAM_COST_LFSR_EN
    end else if (gen_start) begin
      m_mode = 2; m_cnt = 0; m_sum = 0; m_cost = 0;
      m_lfsr = (seed == 16'd0) ? 32'hACE1 : int'(seed);
`endif
    end else if (m_mode == 1) begin
      m_cost = m_tbl[int'(W) * 8 + int'(J)];
    end else begin
      m_cost = 0;
      if (m_mode == 2 || ld_valid) begin
        int v;
        if (m_mode == 2) begin
          int b;
          v = m_lfsr % 128;
          b = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
          m_lfsr = (m_lfsr >> 1) | (b << 15);
        end else begin
          v = int'(ld_data);
        end
        m_tbl[m_cnt] = v;
        m_sum += v;
        m_cnt++;
        if (m_cnt == 64) begin
          m_mode = 1;
          m_cnt  = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Cost"}, 32'(Cost), 32'(m_cost));
    chk({tag, ".ld_sum"}, 32'(ld_sum), 32'(m_sum));
    chk({tag, ".ld_ready"}, 32'(ld_ready), 32'(m_mode == 0));
    chk({tag, ".tbl_ready"}, 32'(tbl_ready), 32'(m_mode == 1));
  endtask

  // One clock: inputs are already stable, model follows the edge, outputs sampled at negedge.
  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all("cyc");
  endtask

  task automatic beat(input int d, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) begin
      ld_valid = 1'b0;
      ld_data  = 7'($urandom);
      cyc();
    end
    ld_valid = 1'b1;
    ld_data  = 7'(d);
    cyc();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    cyc();
    ld_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_all("reset_release");
  endtask

  task automatic random_lookups(input int n);
    for (int i = 0; i < n; i++) begin
      W = 3'($urandom);
      J = 3'($urandom);
      cyc();
    end
  endtask

  initial begin
    RST = 1'b1; W = '0; J = '0; ld_valid = 1'b0; ld_data = '0;
    ld_start = 1'b0; gen_start = 1'b0; seed = '0;
    foreach (m_tbl[i]) m_tbl[i] = 0;
    model_reset();
    vecs[0] = '{w: 3, j: 5, cost: 29};
    vecs[1] = '{w: 7, j: 7, cost: 63};
    vecs[2] = '{w: 0, j: 0, cost: 0};
    vecs[3] = '{w: 0, j: 7, cost: 7};
    vecs[4] = '{w: 7, j: 0, cost: 56};
    vecs[5] = '{w: 4, j: 2, cost: 34};

    repeat (2) @(posedge CLK);
    do_reset();
    chk("reset.ld_ready", 32'(ld_ready), 32'd1);
    chk("reset.tbl_ready", 32'(tbl_ready), 32'd0);
    chk("reset.Cost", 32'(Cost), 32'd0);
    chk("reset.ld_sum", 32'(ld_sum), 32'd0);

    // Entry k = k, back-to-back.
    for (int k = 0; k < 64; k++) begin
      if (k == 63) chk("pre63.tbl_ready", 32'(tbl_ready), 32'd0);
      beat(k, 1'b0);
    end
    chk("load.tbl_ready", 32'(tbl_ready), 32'd1);
    chk("load.ld_sum", 32'(ld_sum), 32'd2016);

    for (int i = 0; i < 6; i++) begin
      W = 3'(vecs[i].w);
      J = 3'(vecs[i].j);
      cyc();
      chk($sformatf("vec%0d.Cost", i), 32'(Cost), 32'(vecs[i].cost));
    end

    // Beats presented while serving must be ignored.
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'($urandom);
      ld_data  = 7'd127;
      W = 3'($urandom);
      J = 3'($urandom);
      cyc();
    end
    ld_valid = 1'b0;
    chk("serve_ignore.ld_sum", 32'(ld_sum), 32'd2016);
    for (int i = 0; i < 6; i++) begin
      W = 3'(vecs[i].w);
      J = 3'(vecs[i].j);
      cyc();
      chk($sformatf("unchanged%0d.Cost", i), 32'(Cost), 32'(vecs[i].cost));
    end

    // Restart, abort after 20 beats, then full random load with gaps.
    pulse_start();
    for (int k = 0; k < 20; k++) beat($urandom_range(0, 127), 1'b1);
    ld_valid = 1'b1;
    ld_data  = 7'd55;
    pulse_start();  // beat in the same cycle is discarded
    ld_valid = 1'b0;
    chk("restart.ld_sum", 32'(ld_sum), 32'd0);
    chk("restart.tbl_ready", 32'(tbl_ready), 32'd0);
    for (int k = 0; k < 64; k++) begin
      if (k == 63) chk("restart_pre63.tbl_ready", 32'(tbl_ready), 32'd0);
      beat($urandom_range(0, 127), 1'b1);
    end
    chk("restart_done.tbl_ready", 32'(tbl_ready), 32'd1);
    random_lookups(40);

    // Diagonal-zero matrix.
    pulse_start();
    for (int k = 0; k < 64; k++) beat(((k / 8) == (k % 8)) ? 0 : 100, 1'b1);
    chk("diag.ld_sum", 32'(ld_sum), 32'd5600);
    W = 3'd2; J = 3'd2; cyc();
    chk("diag22.Cost", 32'(Cost), 32'd0);
    W = 3'd2; J = 3'd6; cyc();
    chk("diag26.Cost", 32'(Cost), 32'd100);
    random_lookups(20);

    // Reset mid-serve, then mid-load.
    do_reset();
    for (int k = 0; k < 30; k++) beat($urandom_range(0, 127), 1'b1);
    do_reset();
    for (int k = 0; k < 64; k++) beat($urandom_range(0, 127), 1'b1);
    random_lookups(20);

`ifdef JAM_COST_LFSR_EN
    seed = 16'd0;
    gen_start = 1'b1;
    ld_valid  = 1'b1;
    cyc();
    gen_start = 1'b0;
    ld_valid  = 1'b0;
    repeat (63) cyc();
    chk("gen_pre.tbl_ready", 32'(tbl_ready), 32'd0);
    cyc();
    chk("gen.tbl_ready", 32'(tbl_ready), 32'd1);
    chk("gen.ld_sum", 32'(ld_sum), 32'(m_sum));
    W = 3'd0; J = 3'd0; cyc();
    chk("gen_first.Cost", 32'(Cost), 32'h61);
    random_lookups(20);
    // ld_start beats gen_start in the same cycle.
    gen_start = 1'b1;
    pulse_start();
    gen_start = 1'b0;
    chk("gen_override.ld_ready", 32'(ld_ready), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
